// File: rtl/clock_switch_ctrl_if.sv
// rtl/clock_switch_ctrl_if.sv - control/status bundle between clock switch controller and its environment
//
// Purpose: groups heartbeat inputs, selection policy inputs and switch/status
// outputs of clock_switch_ctrl so they travel as one port.
// Ports (signals):
//   hb0, hb1   heartbeat levels from the clk0 / clk1 domains (async to clk)
//   pref       preferred source, 1 = clk0, 0 = clk1
//   auto_en    1 = failover enabled, 0 = follow pref unconditionally
//   select     to the glitch-free switch, 1 = clk0
//   busy       settle interval in progress
//   alive0/1   heartbeat of clk0 / clk1 considered live
//   both_dead  failover enabled and neither source alive
//   fail_evt   one-cycle pulse on a failover-caused switch
// Modports: master = environment side, slave = controller side.
interface clock_switch_ctrl_if;
  logic hb0;
  logic hb1;
  logic pref;
  logic auto_en;
  logic select;
  logic busy;
  logic alive0;
  logic alive1;
  logic both_dead;
  logic fail_evt;

  modport master (
    output hb0, hb1, pref, auto_en,
    input  select, busy, alive0, alive1, both_dead, fail_evt
  );

  modport slave (
    input  hb0, hb1, pref, auto_en,
    output select, busy, alive0, alive1, both_dead, fail_evt
  );
endinterface

// File: rtl/clock_switch_ctrl.sv
// rtl/clock_switch_ctrl.sv - source selection, failover and settle control for a two-clock switch
//
// Purpose: watches heartbeat toggles from clk0/clk1 on a free-running
// reference clock, declares a source dead after TIMEOUT quiet cycles, and
// drives the switch select with failover and a SETTLE-cycle hold after
// every change.
// Ports:
//   clk  reference clock, free-running, asynchronous to clk0/clk1
//   rst  synchronous active-high reset
//   bus  clock_switch_ctrl_if.slave (heartbeats, policy inputs, select/status)
module clock_switch_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int SETTLE  = 16
) (
  input  logic                clk,
  input  logic                rst,
  clock_switch_ctrl_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [SW-1:0] SET_LOAD = SW'(SETTLE - 1);

  typedef enum logic {ST_STABLE, ST_SETTLE} state_t;

  // Heartbeat synchronizers: bit 0 = clk0 source, bit 1 = clk1 source.
  logic [1:0]    hb_s1, hb_s2, hb_s3;
  logic [1:0]    hb_edge;
  logic [CW-1:0] cnt0, cnt1;
  logic          alive0, alive1;
  logic          want;

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic          busy_q, busy_d;
  logic          fail_q, fail_d;
  logic [SW-1:0] scnt_q, scnt_d;

  // Both polarities of the heartbeat level count as activity.
  assign hb_edge = hb_s2 ^ hb_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      hb_s1 <= '0;
      hb_s2 <= '0;
      hb_s3 <= '0;
      cnt0  <= '0;
      cnt1  <= '0;
    end else begin
      hb_s1 <= {bus.hb1, bus.hb0};
      hb_s2 <= hb_s1;
      hb_s3 <= hb_s2;
      if (hb_edge[0])          cnt0 <= '0;
      else if (cnt0 != CNT_MAX) cnt0 <= cnt0 + CW'(1);
      if (hb_edge[1])          cnt1 <= '0;
      else if (cnt1 != CNT_MAX) cnt1 <= cnt1 + CW'(1);
    end
  end

  assign alive0 = (cnt0 < CNT_MAX);
  assign alive1 = (cnt1 < CNT_MAX);

  // Target source: preferred if alive, else the other if alive, else hold.
  always_comb begin
    want = sel_q;
    if (!bus.auto_en) begin
      want = bus.pref;
    end else if (bus.pref ? alive0 : alive1) begin
      want = bus.pref;
    end else if (bus.pref ? alive1 : alive0) begin
      want = ~bus.pref;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STABLE;
      sel_q   <= 1'b1;
      busy_q  <= 1'b0;
      fail_q  <= 1'b0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      fail_q  <= fail_d;
      scnt_q  <= scnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    scnt_d  = scnt_q;
    fail_d  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (want != sel_q) begin
          sel_d   = want;
          scnt_d  = SET_LOAD;
          state_d = ST_SETTLE;
          fail_d  = (want != bus.pref);
        end
      end
      ST_SETTLE: begin
        // want is ignored here; it is looked at again in the first STABLE cycle.
        if (scnt_q == '0) state_d = ST_STABLE;
        else              scnt_d  = scnt_q - SW'(1);
      end
      default: state_d = ST_STABLE;
    endcase
    busy_d = (state_d == ST_SETTLE);
  end

  assign bus.select    = sel_q;
  assign bus.busy      = busy_q;
  assign bus.fail_evt  = fail_q;
  assign bus.alive0    = alive0;
  assign bus.alive1    = alive1;
  assign bus.both_dead = bus.auto_en & ~alive0 & ~alive1;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// tb/tb_clock_switch_ctrl.sv - scoreboard testbench for clock_switch_ctrl
module tb_clock_switch_ctrl;
  localparam int TIMEOUT = 64;
  localparam int SETTLE  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clock_switch_ctrl_if ifc ();

  clock_switch_ctrl #(.TIMEOUT(TIMEOUT), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct packed {
    logic sel;
    logic busy;
    logic a0;
    logic a1;
    logic bd;
    logic fe;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stimulus state
  logic [1:0] hb;
  logic [1:0] hb_on;
  logic       pref, auto_en;
  int         step_no;
  int         last_tog0, first_tog0;
  int         last_sel_change, fail_cnt, busy_cnt, sel_changes;
  logic       prev_sel;

  // Reference model, written from the behavioural description
  logic [1:0] ms1, ms2, ms3;
  int         m_since[2];
  logic       m_sel, m_fail;
  int         m_busy_left;

  function automatic logic m_alive(input int i);
    return m_since[i] < TIMEOUT;
  endfunction

  task automatic model_edge();
    logic w;
    logic [1:0] e;
    if (!auto_en)                          w = pref;
    else if (pref ? m_alive(0) : m_alive(1)) w = pref;
    else if (pref ? m_alive(1) : m_alive(0)) w = ~pref;
    else                                   w = m_sel;
    if (rst) begin
      ms1 = '0; ms2 = '0; ms3 = '0;
      m_since[0] = 0; m_since[1] = 0;
      m_sel = 1'b1; m_fail = 1'b0; m_busy_left = 0;
    end else begin
      e = ms2 ^ ms3;
      for (int i = 0; i < 2; i++) begin
        if (e[i])                      m_since[i] = 0;
        else if (m_since[i] < TIMEOUT) m_since[i] = m_since[i] + 1;
      end
      ms3 = ms2; ms2 = ms1; ms1 = hb;
      m_fail = 1'b0;
      if (m_busy_left > 0) begin
        m_busy_left = m_busy_left - 1;
      end else if (w != m_sel) begin
        m_sel = w;
        m_busy_left = SETTLE;
        m_fail = (w != pref);
      end
    end
  endtask

  task automatic step();
    exp_t ex, ob;
    step_no++;
    for (int i = 0; i < 2; i++) begin
      if (hb_on[i] && (step_no % 4 == 0)) begin
        hb[i] = ~hb[i];
        if (i == 0) begin
          last_tog0 = step_no;
          if (first_tog0 < 0) first_tog0 = step_no;
        end
      end
    end
    ifc.hb0 = hb[0];
    ifc.hb1 = hb[1];
    ifc.pref = pref;
    ifc.auto_en = auto_en;
    model_edge();
    ex.sel  = m_sel;
    ex.busy = (m_busy_left > 0);
    ex.a0   = m_alive(0);
    ex.a1   = m_alive(1);
    ex.bd   = auto_en & ~m_alive(0) & ~m_alive(1);
    ex.fe   = m_fail;
    sb_q.push_back(ex);
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      ex = sb_q.pop_front();
      ob = '{ifc.select, ifc.busy, ifc.alive0, ifc.alive1, ifc.both_dead, ifc.fail_evt};
      if (ob != ex) $display("step %0d obs %b exp %b", step_no, ob, ex);
      check("select", ob.sel, ex.sel);
      check("busy", ob.busy, ex.busy);
      check("alive0", ob.a0, ex.a0);
      check("alive1", ob.a1, ex.a1);
      check("both_dead", ob.bd, ex.bd);
      check("fail_evt", ob.fe, ex.fe);
    end
    if (ifc.select !== prev_sel) begin
      last_sel_change = step_no;
      sel_changes++;
    end
    prev_sel = ifc.select;
    if (ifc.fail_evt === 1'b1) fail_cnt++;
    if (ifc.busy === 1'b1) busy_cnt++;
  endtask

  initial begin
    int t0;
    hb = '0; hb_on = 2'b11; pref = 1'b1; auto_en = 1'b1;
    step_no = 0; last_tog0 = 0; first_tog0 = 0;
    last_sel_change = -1; fail_cnt = 0; busy_cnt = 0; sel_changes = 0;
    prev_sel = 1'b1;
    rst = 1'b1;
    step();
    check("rst_select", ifc.select, 1);
    check("rst_busy", ifc.busy, 0);
    check("rst_alive", {ifc.alive0, ifc.alive1}, 2'b11);
    step();
    rst = 1'b0;

    // 1: both alive, preferred clk0
    fail_cnt = 0;
    repeat (500) step();
    check("s1_fail_cnt", fail_cnt, 0);
    check("s1_select", ifc.select, 1);

    // 2: manual mode, pref pulse back during settle
    auto_en = 1'b0; pref = 1'b0; busy_cnt = 0;
    t0 = step_no + 1;
    step();
    check("s2_latency", last_sel_change - t0, 0);
    repeat (3) step();
    pref = 1'b1;
    repeat (40) step();
    check("s2_return_lat", last_sel_change - t0, 17);
    check("s2_busy_cnt", busy_cnt, 2 * SETTLE);
    check("s2_fail_cnt", fail_cnt, 0);

    // 3: clk0 heartbeat dies, then returns
    auto_en = 1'b1; pref = 1'b1;
    repeat (20) step();
    fail_cnt = 0;
    hb_on[0] = 1'b0;
    repeat (100) step();
    check("s3_fail_lat", last_sel_change - last_tog0, TIMEOUT + 3);
    check("s3_fail_cnt", fail_cnt, 1);
    check("s3_select", ifc.select, 0);
    first_tog0 = -1;
    hb_on[0] = 1'b1;
    repeat (30) step();
    check("s3_recover_lat", last_sel_change - first_tog0, 3);
    check("s3_recover_sel", ifc.select, 1);
    check("s3_fail_cnt2", fail_cnt, 1);

    // 4: both dead, then clk1 returns
    repeat (20) step();
    fail_cnt = 0; busy_cnt = 0;
    hb_on = 2'b00;
    repeat (100) step();
    check("s4_both_dead", ifc.both_dead, 1);
    check("s4_select", ifc.select, 1);
    check("s4_busy_cnt", busy_cnt, 0);
    check("s4_fail_cnt", fail_cnt, 0);
    hb_on[1] = 1'b1;
    repeat (30) step();
    check("s4_clk1_sel", ifc.select, 0);
    check("s4_clk1_fail", fail_cnt, 1);
    hb_on[0] = 1'b1;
    repeat (40) step();

    // 5: pref glitch during settle is ignored
    auto_en = 1'b0; pref = 1'b0;
    sel_changes = 0; busy_cnt = 0;
    repeat (2) step();
    pref = 1'b1;
    repeat (3) step();
    pref = 1'b0;
    repeat (30) step();
    check("s5_sel_changes", sel_changes, 1);
    check("s5_select", ifc.select, 0);
    check("s5_busy_cnt", busy_cnt, SETTLE);

    // 6: reset mid-settle
    pref = 1'b1;
    repeat (20) step();
    pref = 1'b0;
    repeat (3) step();
    check("s6_pre_busy", ifc.busy, 1);
    rst = 1'b1;
    step();
    check("s6_select", ifc.select, 1);
    check("s6_busy", ifc.busy, 0);
    check("s6_alive", {ifc.alive0, ifc.alive1}, 2'b11);
    check("s6_fail", ifc.fail_evt, 0);
    rst = 1'b0; pref = 1'b1;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/clock_switch_ctrl.md
Name: clock_switch_ctrl

Overview:
Control-side companion to the glitch-free two-clock switch. It runs on an independent free-running reference clock and monitors heartbeat toggles from the clk0 and clk1 domains. It decides which source the switch should select and drives the switch's `select` input, with automatic failover and a post-switch settle interval. Convention: select=1 chooses clk0; select=0 chooses clk1.

Parameters:
TIMEOUT, 64, number of reference cycles without a heartbeat edge after which a source is declared dead (must be >= 2)
SETTLE, 16, number of cycles `select` is held after any change before another change is accepted (must be >= 1)

Ports:
clk  input  1  reference clock, free-running, asynchronous to clk0/clk1
rst  input  1  reset, synchronous, active-high
hb0  input  1  heartbeat from the clk0 domain: a level that toggles at a divided clk0 rate; asynchronous to clk
hb1  input  1  heartbeat from the clk1 domain; asynchronous to clk
pref  input  1  preferred source: 1=clk0, 0=clk1
auto_en  input  1  1 = failover enabled; 0 = follow pref unconditionally
select  output  1  to clock switch; 1=clk0
busy  output  1  high while in settle interval
alive0  output  1  clk0 heartbeat considered live
alive1  output  1  clk1 heartbeat considered live
both_dead  output  1  auto_en=1 and neither source alive
fail_evt  output  1  one-cycle pulse when a switch is caused by failover (target != pref)

Behaviour:
- Reset (rst=1 at posedge clk): select=1, busy=0, fail_evt=0, state=STABLE, both watchdog counters=0 (so alive0=alive1=1), settle counter=0, synchronizer flops=0. Reset overrides everything, including a settle interval in progress.
- Heartbeat path, per source: 2-flop synchronizer (s1, s2), then a third flop s3. edge = s2 ^ s3. An input toggle captured at edge N produces an edge pulse in cycle N+2. Every toggle counts, whether rising or falling.
- Watchdog, per source: on an edge pulse the counter goes to 0. Otherwise it increments and saturates at TIMEOUT. Width is clog2(TIMEOUT+1).
- aliveX = (cntX < TIMEOUT). aliveX falls exactly TIMEOUT cycles after the last edge pulse. It rises the cycle after the next edge pulse.
- Target (combinational):
  - auto_en=0: want = pref.
  - auto_en=1: want = pref if the preferred source is alive; else the other source if it is alive; else want = select (hold).
- both_dead = auto_en & ~alive0 & ~alive1.
- FSM states:
  - STABLE: busy=0. If want != select, then at the next edge select<=want, settle counter<=SETTLE-1, go to SETTLE. fail_evt is pulsed in that same registered cycle iff want != pref.
  - SETTLE: busy=1. The counter decrements each cycle; when it reaches 0, go to STABLE.
- busy is high for exactly SETTLE cycles per switch.
- Changes in want during SETTLE are ignored. want is re-evaluated in the first STABLE cycle, so a pref pulse that starts and ends inside SETTLE causes no switch.
- Simultaneous pref change and source death: the target is evaluated only by the rule above; there is no priority beyond it.
- Switch latency from a want change while in STABLE: 1 cycle.
- All outputs are registered except alive0, alive1 and both_dead, which decode directly from registers.

Test Plan:
1. Reset; hb0 and hb1 toggling every 4 cycles; pref=1, auto_en=1; run 500 cycles -> select=1, busy=0, alive0=alive1=1, fail_evt never asserted.
2. From scenario 1, auto_en=0; pref 1->0 at cycle T -> select=0 from T+1; busy high T+1..T+16; fail_evt=0. Return pref=1 at T+5 -> select stays 0 until busy drops, then select=1 one cycle later.
3. pref=1, auto_en=1; stop hb0 -> alive0 falls 64 cycles after the last edge pulse; next cycle select=0 and fail_evt pulses for one cycle; busy high 16 cycles. Restart hb0 -> alive0 rises 3 cycles after the first toggle -> select=1 once STABLE, with fail_evt=0.
4. Stop both heartbeats with select=1 -> both_dead=1 after 64 cycles; select held at 1; busy stays 0; no fail_evt. Restart hb1 only -> select=0 and fail_evt pulses.
5. In SETTLE, toggle pref 0->1->0 within 10 cycles -> no additional select change after busy falls.
6. Assert rst for one cycle mid-SETTLE with select=0 -> next cycle select=1, busy=0, alive0=alive1=1, fail_evt=0.
